// File: rtl/tt_vec_player.sv
// rtl/tt_vec_player.sv - vector store and playback/check engine for a Tiny Tapeout user design
// Optional looped playback is built when TT_VEC_LOOP_EN is defined (adds loop_en input).
module tt_vec_player #(
  parameter int IO_W    = 8,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [IO_W-1:0]          load_stim,
  input  logic [IO_W-1:0]          load_exp,
  input  logic [IO_W-1:0]          load_mask,
  input  logic                     clear,
  input  logic                     start,
`ifdef TT_VEC_LOOP_EN
  input  logic                     loop_en,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [IO_W-1:0]          dut_ui,
  input  logic [IO_W-1:0]          dut_uo,
  output logic [CNT_W-1:0]         err_count,
  output logic [$clog2(DEPTH)-1:0] first_err_idx,
  output logic [$clog2(DEPTH):0]   vec_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t state, state_next;

  logic [IO_W-1:0]  stim_mem [DEPTH];
  logic [IO_W-1:0]  exp_mem  [DEPTH];
  logic [IO_W-1:0]  mask_mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [LAT_W-1:0] wait_cnt;
  logic             idle_like;
  logic             load_fire;
  logic             last;
  logic             mismatch;
  logic             loop_on;

`ifdef TT_VEC_LOOP_EN
  assign loop_on = loop_en;
`else
  assign loop_on = 1'b0;
`endif

  assign idle_like  = (state == S_IDLE) || (state == S_DONE);
  assign load_ready = idle_like && (vec_count < (IDX_W+1)'(DEPTH));
  assign load_fire  = load_valid && load_ready;
  assign last       = ({1'b0, idx} == (vec_count - 1'b1));
  assign mismatch   = |((dut_uo ^ exp_mem[idx]) & mask_mem[idx]);

  assign busy = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // A load accepted together with start counts toward the run, so an empty
  // store plus a simultaneous load still plays one vector.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) state_next = ((vec_count == '0) && !load_fire) ? S_DONE : S_APPLY;
        end
        S_APPLY: state_next = S_WAIT;
        S_WAIT:  if (wait_cnt == '0) state_next = S_CHECK;
        S_CHECK: state_next = (last && !loop_on) ? S_DONE : S_APPLY;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) begin
      stim_mem[vec_count[IDX_W-1:0]] <= load_stim;
      exp_mem[vec_count[IDX_W-1:0]]  <= load_exp;
      mask_mem[vec_count[IDX_W-1:0]] <= load_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_count     <= '0;
      idx           <= '0;
      wait_cnt      <= '0;
      dut_ui        <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else if (clear) begin
      vec_count     <= '0;
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      if (load_fire) vec_count <= vec_count + 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx           <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
          end
        end
        S_APPLY: begin
          dut_ui   <= stim_mem[idx];
          wait_cnt <= LAT_W'(LATENCY - 1);
        end
        S_WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        end
        S_CHECK: begin
          // err_count is zero until the first failure of the run, so it doubles as the first-error flag.
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (err_count == '0) first_err_idx <= idx;
          end
          if (!last)        idx <= idx + 1'b1;
          else if (loop_on) idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_vec_player.sv
// tb/tb_tt_vec_player.sv - self-checking bench for tt_vec_player with a timeline-based reference model
module tb_tt_vec_player;

  localparam int P   = 4;
  localparam int BIG = 1 << 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid, load_ready, clear, start, busy, done, pass;
  logic [7:0] load_stim, load_exp, load_mask, dut_ui, dut_uo;
  logic [7:0] err_count;
  logic [3:0] first_err_idx;
  logic [4:0] vec_count;
  logic [7:0] pipe1 = '0, pipe2 = '0;
  bit         loop_on_tb = 1'b0;

  logic       s_load_valid, s_load_ready, s_clear, s_start, s_busy, s_done, s_pass;
  logic [7:0] s_load_stim, s_dut_ui;
  logic [1:0] s_err_count;
  logic [2:0] s_first_err_idx;
  logic [3:0] s_vec_count;

  always #5 clk = ~clk;

  tt_vec_player u_dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
    .clear(clear), .start(start),
`ifdef TT_VEC_LOOP_EN
    .loop_en(loop_on_tb),
`endif
    .busy(busy), .done(done), .pass(pass), .dut_ui(dut_ui), .dut_uo(dut_uo),
    .err_count(err_count), .first_err_idx(first_err_idx), .vec_count(vec_count)
  );

  tt_vec_player #(.IO_W(8), .DEPTH(8), .LATENCY(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .load_valid(s_load_valid), .load_ready(s_load_ready),
    .load_stim(s_load_stim), .load_exp(8'h55), .load_mask(8'hFF),
    .clear(s_clear), .start(s_start),
`ifdef TT_VEC_LOOP_EN
    .loop_en(1'b0),
`endif
    .busy(s_busy), .done(s_done), .pass(s_pass), .dut_ui(s_dut_ui), .dut_uo(8'hAA),
    .err_count(s_err_count), .first_err_idx(s_first_err_idx), .vec_count(s_vec_count)
  );

  // Stand-in user design: response is the stimulus delayed two cycles.
  always @(posedge clk) begin
    pipe1 <= dut_ui;
    pipe2 <= pipe1;
  end
  assign dut_uo = pipe2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  logic [7:0] m_stim [16];
  logic [7:0] m_exp  [16];
  logic [7:0] m_mask [16];
  int         m_n = 0;
  logic [7:0] m_ui = '0;
  bit         m_run = 1'b0;
  int         run_s = 0, run_n = 0, run_t = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic bit vec_fails(int k);
    return |((m_stim[k] ^ m_exp[k]) & m_mask[k]);
  endfunction

  function automatic bit exp_busy(int c);
    return m_run && (run_n > 0) && ((c - run_s) <= run_t * P);
  endfunction

  function automatic bit exp_done(int c);
    return m_run && ((c - run_s) > run_t * P);
  endfunction

  function automatic logic [7:0] exp_ui(int c);
    int k;
    if (!m_run || run_n == 0 || (c - run_s) < 2) return m_ui;
    k = (c - run_s - 2) / P;
    if (k > run_t - 1) k = run_t - 1;
    return m_stim[k % run_n];
  endfunction

  function automatic int n_checked(int c);
    int nc;
    if (!m_run) return 0;
    nc = (c - run_s - 1) / P;
    if (nc > run_t) nc = run_t;
    return nc;
  endfunction

  function automatic int exp_err(int c);
    int e = 0;
    for (int k = 0; k < n_checked(c); k++) if (vec_fails(k % run_n)) e++;
    return (e > 255) ? 255 : e;
  endfunction

  function automatic int exp_first(int c);
    for (int k = 0; k < n_checked(c); k++) if (vec_fails(k % run_n)) return k % run_n;
    return 0;
  endfunction

  function automatic bit exp_ready(int c);
    return !exp_busy(c) && (m_n < 16);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", busy, exp_busy(cyc));
      cmp("done", done, exp_done(cyc));
      cmp("pass", pass, exp_done(cyc) && exp_err(cyc) == 0);
      cmp("dut_ui", dut_ui, exp_ui(cyc));
      cmp("err_count", err_count, exp_err(cyc));
      cmp("first_err_idx", first_err_idx, exp_first(cyc));
      cmp("vec_count", vec_count, m_n);
      cmp("load_ready", load_ready, exp_ready(cyc));
    end
  end

  // Called aligned (#1 after a rising edge); the inputs are consumed at the next edge.
  task automatic drive(input bit ld, input logic [7:0] st_w, input logic [7:0] ex_w,
                       input logic [7:0] mk_w, input bit stt, input bit clr, input bit rs);
    int e;
    load_valid = ld; load_stim = st_w; load_exp = ex_w; load_mask = mk_w;
    start = stt; clear = clr; rst = rs;
    e = cyc;
    @(posedge clk); #1;
    load_valid = 0; start = 0; clear = 0; rst = 0;
    if (rs) begin
      m_n = 0; m_ui = '0; m_run = 0;
    end else if (clr) begin
      m_ui = exp_ui(e); m_n = 0; m_run = 0;
    end else begin
      if (ld && exp_ready(e)) begin
        m_stim[m_n] = st_w; m_exp[m_n] = ex_w; m_mask[m_n] = mk_w; m_n++;
      end
      if (stt && !exp_busy(e)) begin
        m_ui = exp_ui(e); m_run = 1; run_s = e; run_n = m_n;
        run_t = (loop_on_tb && m_n > 0) ? BIG : m_n;
      end
    end
  endtask

  task automatic load(input logic [7:0] st_w, input logic [7:0] ex_w, input logic [7:0] mk_w);
    drive(1, st_w, ex_w, mk_w, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin @(posedge clk); #1; n++; end
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [7:0] v;
    rst = 1; load_valid = 0; load_stim = 0; load_exp = 0; load_mask = 0; clear = 0; start = 0;
    s_load_valid = 0; s_load_stim = 0; s_clear = 0; s_start = 0;
    repeat (3) @(posedge clk);
    #1; rst = 0; chk_en = 1;

    cmp("reset vec_count", vec_count, 0);
    cmp("reset load_ready", load_ready, 1);
    cmp("reset dut_ui", dut_ui, 0);
    cmp("reset done/pass/busy", {busy, done, pass}, 3'b000);

    // Clean run of four vectors; a load while busy is refused.
    for (int i = 1; i <= 4; i++) load(8'(i), 8'(i), 8'hFF);
    drive(0, 0, 0, 0, 1, 0, 0);
    t0 = cyc;
    drive(1, 8'h77, 8'h77, 8'hFF, 1, 0, 0);
    wait_done(40);
    cmp("run4 latency", cyc - t0, 16);
    cmp("run4 pass", pass, 1);
    cmp("run4 err_count", err_count, 0);
    cmp("busy load refused", vec_count, 4);

    // exp[2] wrong, then masked off.
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) load(8'(i), (i == 3) ? 8'h00 : 8'(i), 8'hFF);
    drive(0, 0, 0, 0, 1, 0, 0);
    wait_done(40);
    cmp("exp2 err_count", err_count, 1);
    cmp("exp2 first_err_idx", first_err_idx, 2);
    cmp("exp2 pass", pass, 0);
    cmp("exp2 dut_ui holds last", dut_ui, 8'h04);
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) load(8'(i), (i == 3) ? 8'h00 : 8'(i), (i == 3) ? 8'h00 : 8'hFF);
    drive(0, 0, 0, 0, 1, 0, 0);
    wait_done(40);
    cmp("mask2 pass", pass, 1);

    // Full store: 16 vectors, failures at 3,6,9,12 (0 and 15 masked).
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom_range(0, 255));
      load(v, (i % 3 == 0) ? (v ^ 8'h10) : v, (i % 5 == 0) ? 8'hEF : 8'hFF);
    end
    cmp("full load_ready", load_ready, 0);
    load(8'h99, 8'h99, 8'hFF);
    cmp("full vec_count", vec_count, 16);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(10);
    drive(0, 0, 0, 0, 1, 0, 0);
    wait_done(80);
    cmp("full err_count", err_count, 4);
    cmp("full first_err_idx", first_err_idx, 3);

    // Empty start goes straight to DONE; then load+start in one cycle.
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    cmp("empty start done/pass", {done, pass}, 2'b11);
    drive(1, 8'h5A, 8'h5A, 8'hFF, 1, 0, 0);
    cmp("load+start busy", busy, 1);
    wait_done(20);
    cmp("load+start dut_ui", dut_ui, 8'h5A);
    cmp("load+start vec_count", vec_count, 1);

    // Reset during WAIT of vector 1.
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) load(8'(i), 8'(i), 8'hFF);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(5);
    drive(0, 0, 0, 0, 0, 0, 1);
    cmp("rst dut_ui", dut_ui, 0);
    cmp("rst vec_count", vec_count, 0);
    cmp("rst flags", {busy, done, pass, load_ready}, 4'b0001);

    // Clear mid-run.
    load(8'h10, 8'h00, 8'hFF);
    load(8'h20, 8'h20, 8'hFF);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(3);
    drive(0, 0, 0, 0, 0, 1, 0);
    cmp("clear flags", {busy, done, pass}, 3'b000);
    cmp("clear vec_count", vec_count, 0);

`ifdef TT_VEC_LOOP_EN
    load(8'h11, 8'h00, 8'hFF);
    load(8'h22, 8'h00, 8'hFF);
    loop_on_tb = 1;
    drive(0, 0, 0, 0, 1, 0, 0);
    t0 = run_s;
    idle(19);
    loop_on_tb = 0;
    run_t = run_n * (((cyc - run_s) + run_n * P - 1) / (run_n * P));
    wait_done(40);
    cmp("loop err_count", err_count, 6);
    cmp("loop first_err_idx", first_err_idx, 0);
    cmp("loop duration", cyc - t0, 25);
`endif

    // Saturating error counter on the narrow instance.
    for (int i = 0; i < 8; i++) begin
      s_load_valid = 1; s_load_stim = 8'(i);
      @(posedge clk); #1;
    end
    s_load_valid = 0;
    cmp("sat vec_count", s_vec_count, 8);
    cmp("sat load_ready", s_load_ready, 0);
    s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    for (int n = 0; n < 60 && s_done !== 1'b1; n++) begin @(posedge clk); #1; end
    cmp("sat done", s_done, 1);
    cmp("sat err_count", s_err_count, 3);
    cmp("sat first_err_idx", s_first_err_idx, 0);
    cmp("sat pass", s_pass, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
